// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   - 2-bit frame state encoding (IDLE/START/DATA/STOP)
//   - default frame geometry (WORD, OVERSAMPLE, SB_TICK)
//   - helpers for sizing the tick and bit counters
package uart_pkg;

   localparam int WORD_DEF       = 8;
   localparam int OVERSAMPLE_DEF = 16;
   localparam int SB_TICK_DEF    = 16;

   typedef logic [1:0] state_t;

   localparam state_t IDLE  = 2'd0;
   localparam state_t START = 2'd1;
   localparam state_t DATA  = 2'd2;
   localparam state_t STOP  = 2'd3;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Bits needed to count 0..n-1. A counter is never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a first-word-fall-through byte FIFO and serialises each
// word onto a UART TX line. Frame: start bit (0), WORD data bits LSB first, and
// a stop period (1). The idle line is 1.
//
// Ports
//   i_clock       system clock, rising edge
//   i_reset       synchronous, active-high reset
//   i_tick        baud tick, one-clock pulse at OVERSAMPLE x baud rate
//   i_fifo_empty  FIFO empty flag
//   i_fifo_data   FIFO head word, valid while i_fifo_empty = 0
//   o_fifo_read   pop strobe; the FIFO pops on the rising edge where it is 1
//   o_tx          serial line (registered)
//   o_busy        1 from start bit through stop period (registered)
//   o_tx_done     one-clock pulse after the stop period completes
module fifo_uart_tx
   import uart_pkg::*;
#(
   parameter int WORD       = WORD_DEF,
   parameter int OVERSAMPLE = OVERSAMPLE_DEF,
   parameter int SB_TICK    = SB_TICK_DEF
) (
   input  logic            i_clock,
   input  logic            i_reset,
   input  logic            i_tick,
   input  logic            i_fifo_empty,
   input  logic [WORD-1:0] i_fifo_data,
   output logic            o_fifo_read,
   output logic            o_tx,
   output logic            o_busy,
   output logic            o_tx_done
);

   localparam int TICK_W = cnt_width(max_int(OVERSAMPLE, SB_TICK));
   localparam int BIT_W  = cnt_width(WORD);

   localparam logic [TICK_W-1:0] BIT_LAST_TICK  = TICK_W'(OVERSAMPLE - 1);
   localparam logic [TICK_W-1:0] STOP_LAST_TICK = TICK_W'(SB_TICK - 1);
   localparam logic [BIT_W-1:0]  LAST_BIT       = BIT_W'(WORD - 1);

   state_t            state,    state_nx;
   logic [TICK_W-1:0] tick_cnt, tick_cnt_nx;
   logic [BIT_W-1:0]  bit_cnt,  bit_cnt_nx;
   logic [WORD-1:0]   shreg,    shreg_nx;
   logic              tx_q,     tx_nx;
   logic              busy_q,   busy_nx;
   logic              done_q,   done_nx;

   // State register
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of process ordering.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state    <= IDLE;
         tick_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state    <= state_nx;
         tick_cnt <= tick_cnt_nx;
         bit_cnt  <= bit_cnt_nx;
         shreg    <= shreg_nx;
         tx_q     <= tx_nx;
         busy_q   <= busy_nx;
         done_q   <= done_nx;
      end
   end

   // Next-state logic
   // NOTE: every variable gets a hold/default value before the case so no
   // path leaves it unassigned, which would infer a latch.
   always_comb begin
      state_nx    = state;
      tick_cnt_nx = tick_cnt;
      bit_cnt_nx  = bit_cnt;
      shreg_nx    = shreg;
      done_nx     = 1'b0;

      case (state)
         IDLE: begin
            // Same condition as o_fifo_read, so the word is latched on the pop edge.
            if (!i_fifo_empty) begin
               shreg_nx    = i_fifo_data;
               tick_cnt_nx = '0;
               state_nx    = START;
            end
         end
         START: begin
            if (i_tick) begin
               if (tick_cnt == BIT_LAST_TICK) begin
                  tick_cnt_nx = '0;
                  bit_cnt_nx  = '0;
                  state_nx    = DATA;
               end else begin
                  tick_cnt_nx = tick_cnt + 1'b1;
               end
            end
         end
         DATA: begin
            if (i_tick) begin
               if (tick_cnt == BIT_LAST_TICK) begin
                  tick_cnt_nx = '0;
                  shreg_nx    = shreg >> 1;
                  if (bit_cnt == LAST_BIT) begin
                     state_nx = STOP;
                  end else begin
                     bit_cnt_nx = bit_cnt + 1'b1;
                  end
               end else begin
                  tick_cnt_nx = tick_cnt + 1'b1;
               end
            end
         end
         STOP: begin
            if (i_tick) begin
               if (tick_cnt == STOP_LAST_TICK) begin
                  tick_cnt_nx = '0;
                  state_nx    = IDLE;
                  done_nx     = 1'b1;
               end else begin
                  tick_cnt_nx = tick_cnt + 1'b1;
               end
            end
         end
         default: state_nx = IDLE;
      endcase

      // Line and busy are derived from the next state so their registers
      // change on the same edge as the state itself.
      case (state_nx)
         START:   begin tx_nx = 1'b0;        busy_nx = 1'b1; end
         DATA:    begin tx_nx = shreg_nx[0]; busy_nx = 1'b1; end
         STOP:    begin tx_nx = 1'b1;        busy_nx = 1'b1; end
         default: begin tx_nx = 1'b1;        busy_nx = 1'b0; end
      endcase
   end

   // Outputs
   always_comb begin
      // Reset gates the pop so a word is never consumed while the FSM is held.
      o_fifo_read = (state == IDLE) && !i_fifo_empty && !i_reset;
      o_tx        = tx_q;
      o_busy      = busy_q;
      o_tx_done   = done_q;
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: scoreboard bench for fifo_uart_tx.
// Stimulus pushes words into an FWFT FIFO model and the expected byte into
// exp_q; a line monitor decodes o_tx and compares each received frame.
// A second instance with SB_TICK=32 and i_tick held high checks exact timing.
module tb_fifo_uart_tx;

   logic       clk;
   logic       rst;
   logic       tick;
   logic       fifo_empty;
   logic [7:0] fifo_data;
   logic       rd, tx, busy, done;

   logic       tick2;
   logic       fifo2_empty;
   logic [7:0] fifo2_data;
   logic       rd2, tx2, busy2, done2;

   fifo_uart_tx dut (
      .i_clock     (clk),
      .i_reset     (rst),
      .i_tick      (tick),
      .i_fifo_empty(fifo_empty),
      .i_fifo_data (fifo_data),
      .o_fifo_read (rd),
      .o_tx        (tx),
      .o_busy      (busy),
      .o_tx_done   (done)
   );

   fifo_uart_tx #(.SB_TICK(32)) dut2 (
      .i_clock     (clk),
      .i_reset     (rst),
      .i_tick      (tick2),
      .i_fifo_empty(fifo2_empty),
      .i_fifo_data (fifo2_data),
      .o_fifo_read (rd2),
      .o_tx        (tx2),
      .o_busy      (busy2),
      .o_tx_done   (done2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [7:0] fifo_q[$];
   logic [7:0] fifo2_q[$];
   logic [7:0] exp_q[$];
   int pops = 0, pops2 = 0, done_cnt = 0;
   int tick_ph = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h at %0t", name, got, want, $time);
      end
   endtask

   task automatic refresh();
      fifo_empty  = (fifo_q.size() == 0);
      fifo_data   = fifo_empty ? 8'h00 : fifo_q[0];
      fifo2_empty = (fifo2_q.size() == 0);
      fifo2_data  = fifo2_empty ? 8'h00 : fifo2_q[0];
   endtask

   // One clock: FIFO pops, tick generation, then settle. Returns at posedge+2.
   task automatic step();
      logic p1, p2;
      @(posedge clk);
      p1 = rd;
      p2 = rd2;
      #1;
      if (p1) begin
         if (fifo_q.size() == 0) check("pop_when_empty", 1, 0);
         else void'(fifo_q.pop_front());
         pops++;
      end
      if (p2) begin
         if (fifo2_q.size() == 0) check("pop2_when_empty", 1, 0);
         else void'(fifo2_q.pop_front());
         pops2++;
      end
      tick_ph = (tick_ph + 1) % 4;
      tick    = (tick_ph == 0);
      refresh();
      #1;
      if (done === 1'b1) done_cnt++;
   endtask

   task automatic push(input logic [7:0] b, input bit expect_frame);
      fifo_q.push_back(b);
      if (expect_frame) exp_q.push_back(b);
      refresh();
      #1;
   endtask

   task automatic wait_busy(input bit second, input int limit);
      int n = 0;
      while ((second ? busy2 : busy) !== 1'b1) begin
         step();
         n++;
         if (n >= limit) begin
            check("busy_timeout", 0, 1);
            return;
         end
      end
   endtask

   task automatic wait_done(input int limit, output int n);
      n = 0;
      forever begin
         step();
         n++;
         if (done === 1'b1) return;
         if (n >= limit) begin
            check("done_timeout", 0, 1);
            return;
         end
      end
   endtask

   // Line monitor: falling edge starts a frame; bits sampled mid-bit
   // (64 clocks per bit at one tick every 4 clocks). Reset aborts a frame.
   bit         mon_act = 0;
   int         mon_cnt = 0;
   logic       tx_prev = 1'b1;
   logic [7:0] mon_byte;

   always @(negedge clk) begin
      if (rst === 1'b1) begin
         mon_act = 0;
      end else if (!mon_act) begin
         if (tx === 1'b0 && tx_prev === 1'b1) begin
            mon_act = 1;
            mon_cnt = 0;
         end
      end else begin
         mon_cnt++;
         if (mon_cnt == 32) begin
            check("mon_start_bit", tx, 0);
         end else if (mon_cnt > 32 && ((mon_cnt - 32) % 64) == 0) begin
            if ((mon_cnt - 32) / 64 <= 8) begin
               mon_byte[(mon_cnt - 32) / 64 - 1] = tx;
            end else begin
               check("mon_stop_bit", tx, 1);
               if (exp_q.size() == 0) check("mon_unexpected_frame", {24'h0, mon_byte}, 32'hFFFF_FFFF);
               else check("mon_frame_byte", {24'h0, mon_byte}, {24'h0, exp_q.pop_front()});
               mon_act = 0;
            end
         end
      end
      tx_prev = tx;
   end

   initial begin
      int len, errs, d0;
      logic exp_b;

      rst   = 1'b1;
      tick  = 1'b0;
      tick2 = 1'b1;
      refresh();

      // 1: reset with a word waiting
      push(8'h3C, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_tx", tx, 1);
         check("rst_read", rd, 0);
         check("rst_busy", busy, 0);
      end
      rst = 1'b0;
      #1;
      check("release_read", rd, 1);
      step();
      check("release_pops", pops, 1);
      check("release_busy", busy, 1);
      check("release_tx_start", tx, 0);
      wait_done(800, len);
      check("t1_done_cnt", done_cnt, 1);

      // 2: single word AA
      push(8'hAA, 1'b1);
      wait_busy(0, 10);
      wait_done(800, len);
      check("t2_frame_len_637_640", (len >= 637 && len <= 640), 1);
      check("t2_done_cnt", done_cnt, 2);
      check("t2_pops", pops, 2);
      check("t2_idle_tx", tx, 1);
      check("t2_idle_busy", busy, 0);

      // 3: back-to-back FF, 81
      push(8'hFF, 1'b1);
      push(8'h81, 1'b1);
      wait_busy(0, 10);
      wait_done(800, len);
      check("t3_pop_in_done_cycle", rd, 1);
      check("t3_gap_tx_high", tx, 1);
      step();
      check("t3_second_busy", busy, 1);
      check("t3_second_start", tx, 0);
      check("t3_pops", pops, 4);
      wait_done(800, len);
      check("t3_second_len", (len >= 637 && len <= 640), 1);
      check("t3_done_cnt", done_cnt, 4);

      // 4: empty FIFO with ticks running
      errs = 0;
      d0 = done_cnt;
      repeat (2000) begin
         step();
         if (tx !== 1'b1 || rd !== 1'b0 || busy !== 1'b0) errs++;
      end
      check("t4_idle_quiet_errs", errs, 0);
      check("t4_no_done", done_cnt, d0);

      // 5: reset during data bit 3 of F0, then 55
      push(8'hF0, 1'b0);
      wait_busy(0, 10);
      repeat (285) step();
      check("t5_midframe_busy", busy, 1);
      d0 = done_cnt;
      rst = 1'b1;
      step();
      check("t5_rst_tx", tx, 1);
      check("t5_rst_busy", busy, 0);
      step();
      rst = 1'b0;
      #1;
      check("t5_word_dropped_read", rd, 0);
      check("t5_pops", pops, 5);
      check("t5_no_done", done_cnt, d0);
      push(8'h55, 1'b1);
      wait_busy(0, 10);
      wait_done(800, len);
      check("t5_clean_len", (len >= 637 && len <= 640), 1);
      check("t5_pops_after", pops, 6);

      // 6: tick held high, SB_TICK=32, word 01
      fifo2_q.push_back(8'h01);
      refresh();
      #1;
      wait_busy(1, 10);
      check("t6_start_tx", tx2, 0);
      errs = 0;
      for (int c = 1; c < 176; c++) begin
         step();
         exp_b = (c < 16) ? 1'b0 : (c < 32) ? 1'b1 : (c < 144) ? 1'b0 : 1'b1;
         if (tx2 !== exp_b || done2 !== 1'b0 || busy2 !== 1'b1) errs++;
      end
      check("t6_waveform_errs", errs, 0);
      step();
      check("t6_done_at_176", done2, 1);
      check("t6_idle_busy", busy2, 0);
      check("t6_pops2", pops2, 1);

      repeat (5) step();
      check("exp_queue_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
